// File: rtl/lsu_master.sv
// Load/store initiator for a big-endian, word-wide data memory port.
// Handles alignment checks, lane extract/extend and read-modify-write for sub-word stores.
//
// state | meaning
// IDLE  | waiting for req
// READ  | mem_read high, word fetched for load or merge
// WRITE | mem_write high, full word presented
// DONE  | done pulse, err valid
module lsu_master #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data,
  output logic              mem_write,
  output logic              mem_read
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t      state, state_nxt;
  logic        we_q;
  logic [1:0]  size_q;
  logic        sign_q;
  logic [1:0]  off_q;
  logic [15:0] wdata_q;

  logic        illegal;
  logic [4:0]  sh;
  logic [31:0] lane_mask, lane_val, rd_shift, load_val;

  assign busy = (state != IDLE);

  always_comb begin
    state_nxt = state;
    illegal   = (size == 2'b11) ||
                (size == 2'b01 && addr[0]) ||
                (size == 2'b10 && addr[1:0] != 2'b00);

    // Big-endian: byte k sits 8*(3-k) bits up; half at offset 0 sits 16 bits up.
    if (size_q == 2'b00) begin
      sh        = {~off_q, 3'b000};
      lane_mask = 32'h0000_00ff << sh;
      lane_val  = {24'b0, wdata_q[7:0]} << sh;
    end else begin
      sh        = {~off_q[1], 4'b0000};
      lane_mask = 32'h0000_ffff << sh;
      lane_val  = {16'b0, wdata_q} << sh;
    end
    rd_shift = mem_read_data >> sh;

    case (size_q)
      2'b00:   load_val = sign_q ? {{24{rd_shift[7]}}, rd_shift[7:0]}
                                 : {24'b0, rd_shift[7:0]};
      2'b01:   load_val = sign_q ? {{16{rd_shift[15]}}, rd_shift[15:0]}
                                 : {16'b0, rd_shift[15:0]};
      default: load_val = mem_read_data;
    endcase

    case (state)
      IDLE: begin
        if (req) begin
          if (illegal)                   state_nxt = DONE;
          else if (we && size == 2'b10)  state_nxt = WRITE;
          else                           state_nxt = READ;
        end
      end
      READ:    state_nxt = we_q ? WRITE : DONE;
      WRITE:   state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      done           <= 1'b0;
      err            <= 1'b0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      rdata          <= 32'b0;
      mem_address    <= '0;
      mem_write_data <= 32'b0;
      we_q           <= 1'b0;
      size_q         <= 2'b0;
      sign_q         <= 1'b0;
      off_q          <= 2'b0;
      wdata_q        <= 16'b0;
    end else begin
      state     <= state_nxt;
      mem_read  <= (state_nxt == READ);
      mem_write <= (state_nxt == WRITE);
      done      <= (state_nxt == DONE);
      err       <= (state == IDLE) && req && illegal;

      if (state == IDLE && req) begin
        we_q        <= we;
        size_q      <= size;
        sign_q      <= sign_ext;
        off_q       <= addr[1:0];
        wdata_q     <= wdata[15:0];
        mem_address <= {addr[ADDR_W-1:2], 2'b00};
        if (we && size == 2'b10)
          mem_write_data <= wdata;
      end

      if (state == READ) begin
        if (we_q)
          mem_write_data <= (mem_read_data & ~lane_mask) | lane_val;
        else
          rdata <= load_val;
      end
    end
  end

endmodule

// File: tb/tb_lsu_master.sv
// Directed bench for lsu_master with a byte-array big-endian memory model.
module tb_lsu_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, we, sign_ext;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        busy, done, err, mem_write, mem_read;
  logic [31:0] rdata, mem_address, mem_write_data, mem_read_data;

  logic [7:0]  mem [256];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          overlap = 0;

  lsu_master #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size),
    .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .busy(busy),
    .done(done), .err(err), .rdata(rdata), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .mem_write(mem_write), .mem_read(mem_read)
  );

  always #5 clk = ~clk;

  always_comb begin
    logic [7:0] a;
    a = {mem_address[7:2], 2'b00};
    mem_read_data = {mem[a], mem[a | 8'd1], mem[a | 8'd2], mem[a | 8'd3]};
  end

  always @(posedge clk) begin
    if (mem_write) begin
      logic [7:0] a;
      a = {mem_address[7:2], 2'b00};
      mem[a]        <= mem_write_data[31:24];
      mem[a | 8'd1] <= mem_write_data[23:16];
      mem[a | 8'd2] <= mem_write_data[15:8];
      mem[a | 8'd3] <= mem_write_data[7:0];
    end
  end

  always @(negedge clk) if (mem_read && mem_write) overlap++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return {mem[a], mem[a + 8'd1], mem[a + 8'd2], mem[a + 8'd3]};
  endfunction

  // One transaction; latency 0 means done never came within the budget.
  task automatic run_txn(input logic t_we, input logic [1:0] t_size, input logic t_sign,
                         input logic [31:0] t_addr, input logic [31:0] t_wdata,
                         input logic hold_req,
                         output int lat, output int n_rd, output int n_wr,
                         output logic t_err, output logic addr_ok,
                         output logic [31:0] wd_seen, output int extra);
    @(negedge clk);
    req = 1'b1; we = t_we; size = t_size; sign_ext = t_sign;
    addr = t_addr; wdata = t_wdata;
    lat = 0; n_rd = 0; n_wr = 0; t_err = 1'b0; addr_ok = 1'b1;
    wd_seen = 32'h0; extra = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (!hold_req) req = 1'b0;
      if (mem_read) begin
        n_rd++;
        if (mem_address !== {t_addr[31:2], 2'b00}) addr_ok = 1'b0;
      end
      if (mem_write) begin
        n_wr++;
        wd_seen = mem_write_data;
      end
      if (done) begin
        lat = c; t_err = err; req = 1'b0;
        break;
      end
    end
    req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done) extra++;
    end
  endtask

  int          lat, n_rd, n_wr, extra;
  logic        t_err, addr_ok;
  logic [31:0] wd;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'h88; mem[8'h11] = 8'h99; mem[8'h12] = 8'hAA; mem[8'h13] = 8'hBB;
    rst_n = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; sign_ext = 1'b0;
    addr = 32'h0; wdata = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_state", {busy, done, err, mem_read, mem_write}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_addr", mem_address, 32'h0);
    check("rst_wdata", mem_write_data, 32'h0);
    rst_n = 1'b1;

    run_txn(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 1'b0, lat, n_rd, n_wr, t_err, addr_ok, wd, extra);
    check("lb_s_lat", lat, 2);
    check("lb_s_data", rdata, 32'hFFFFFF99);
    check("lb_s_rw", {n_rd[7:0], n_wr[7:0]}, 32'h0100);
    check("lb_s_addr", addr_ok, 1);

    run_txn(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 1'b0, lat, n_rd, n_wr, t_err, addr_ok, wd, extra);
    check("lb_z_data", rdata, 32'h00000099);
    check("lb_z_err", t_err, 0);

    run_txn(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b0, lat, n_rd, n_wr, t_err, addr_ok, wd, extra);
    check("lh_s_data", rdata, 32'hFFFFAABB);
    check("lh_s_addr", addr_ok, 1);

    run_txn(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, lat, n_rd, n_wr, t_err, addr_ok, wd, extra);
    check("lw_data", rdata, 32'h8899AABB);
    check("lw_lat", lat, 2);
    check("lw_addr", addr_ok, 1);

    run_txn(1'b1, 2'b00, 1'b0, 32'h12, 32'h1234565C, 1'b0, lat, n_rd, n_wr, t_err, addr_ok, wd, extra);
    check("sb_lat", lat, 3);
    check("sb_rw", {n_rd[7:0], n_wr[7:0]}, 32'h0101);
    check("sb_wdata", wd, 32'h88995CBB);
    check("sb_rdata_kept", rdata, 32'h8899AABB);
    check("sb_mem", mem_word(8'h10), 32'h88995CBB);
    run_txn(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, lat, n_rd, n_wr, t_err, addr_ok, wd, extra);
    check("sb_readback", rdata, 32'h88995CBB);

    run_txn(1'b1, 2'b10, 1'b0, 32'h14, 32'hDEADBEEF, 1'b0, lat, n_rd, n_wr, t_err, addr_ok, wd, extra);
    check("sw_lat", lat, 2);
    check("sw_rw", {n_rd[7:0], n_wr[7:0]}, 32'h0001);
    check("sw_mem", mem_word(8'h14), 32'hDEADBEEF);

    run_txn(1'b0, 2'b01, 1'b1, 32'h13, 32'h0, 1'b1, lat, n_rd, n_wr, t_err, addr_ok, wd, extra);
    check("mis_lat", lat, 1);
    check("mis_err", t_err, 1);
    check("mis_rw", {n_rd[7:0], n_wr[7:0]}, 32'h0000);
    check("mis_rdata", rdata, 32'h88995CBB);
    check("mis_extra", extra, 0);

    run_txn(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1'b1, lat, n_rd, n_wr, t_err, addr_ok, wd, extra);
    check("ill_lat", lat, 1);
    check("ill_err", t_err, 1);
    check("ill_rw", {n_rd[7:0], n_wr[7:0]}, 32'h0000);
    check("ill_rdata", rdata, 32'h88995CBB);

    run_txn(1'b1, 2'b01, 1'b0, 32'h10, 32'h1111CAFE, 1'b1, lat, n_rd, n_wr, t_err, addr_ok, wd, extra);
    check("sh_lat", lat, 3);
    check("sh_wdata", wd, 32'hCAFE5CBB);
    check("sh_extra", extra, 0);
    run_txn(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 1'b0, lat, n_rd, n_wr, t_err, addr_ok, wd, extra);
    check("lh_z_data", rdata, 32'h0000CAFE);

    // Reset lands on the edge that would enter WRITE.
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'b00; addr = 32'h12; wdata = 32'h00000077;
    @(negedge clk);
    req = 1'b0;
    check("rmw_in_read", mem_read, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_write", mem_write, 0);
    check("rst_mid_busy", busy, 0);
    extra = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("rst_mid_done", extra, 0);
    check("rst_mid_mem", mem_word(8'h10), 32'hCAFE5CBB);
    check("rst_mid_rdata", rdata, 32'h0);
    rst_n = 1'b1;

    run_txn(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1'b0, lat, n_rd, n_wr, t_err, addr_ok, wd, extra);
    check("post_rst_lat", lat, 2);
    check("post_rst_data", rdata, 32'hFFFFFFBB);

    check("rw_overlap", overlap, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_master.md
Name: lsu_master

Overview:
- Load/store initiator that drives the byte-addressed, big-endian, word-wide data memory port (address, write_data, read_data, memwrite, memread) on behalf of the datapath.
- Accepts one byte, halfword or word load/store request per transaction.
- Performs alignment checking, big-endian lane extraction with sign/zero extension, and read-modify-write for sub-word stores.
- Sits between the execute stage and the data memory; it is the only master on that port.

Parameters:
- ADDR_W, 32, width of the request address; mem_address is ADDR_W bits wide.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  synchronous active-low reset, sampled on posedge clk.
- req  input  1  request strobe; sampled only in IDLE.
- we  input  1  1 = store, 0 = load.
- size  input  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- sign_ext  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
- addr  input  ADDR_W  byte address.
- wdata  input  32  store data; the byte or half is taken from the LSBs.
- busy  output  1  high in every non-IDLE state.
- done  output  1  one-cycle completion pulse.
- err  output  1  valid with done: 1 = misaligned or illegal size.
- rdata  output  32  load result; valid from the done cycle and held until the next successful load completes.
- mem_address  output  ADDR_W  word-aligned memory address (addr with bits [1:0] cleared).
- mem_write_data  output  32  full word to write.
- mem_read_data  input  32  combinational read data from memory.
- mem_write  output  1  write enable; memory commits on the next posedge.
- mem_read  output  1  read enable.

Behaviour:
- Reset (rst_n=0 at posedge):
  - state goes to IDLE.
  - busy, done, err, mem_write, mem_read = 0.
  - rdata, mem_address, mem_write_data = 0.
  - Reset overrides every state. A transaction in flight is abandoned with no done pulse; a write not yet clocked into memory is dropped.
- Request capture: in IDLE with req=1, we, size, sign_ext, addr and wdata are registered into internal copies and the FSM leaves IDLE. req is ignored in all other states, including DONE, so requests are spaced at least (latency+1) cycles apart.
- Byte lanes: big-endian. Offset k = addr[1:0].
  - Byte k occupies bits [31-8k : 24-8k].
  - Half at offset 0 occupies [31:16]; half at offset 2 occupies [15:0].
- Alignment check: half requires addr[0]=0; word requires addr[1:0]=00. size=11 is always illegal.
- FSM states: IDLE, READ, WRITE, DONE. mem_* outputs are registered.
  - IDLE -> DONE with err=1 if the request is illegal or misaligned. No mem_read or mem_write is issued; done is asserted the cycle after capture.
  - IDLE -> READ for any load, and for byte/half stores.
  - IDLE -> WRITE for word stores.
  - READ:
    - mem_read=1 and mem_address is the aligned address.
    - At the end of the cycle, mem_read_data is captured.
    - Load: the lane is extracted and extended into rdata, then -> DONE.
    - Sub-word store: the store lane is merged into the captured word, preserving the other bytes, then -> WRITE.
  - WRITE:
    - mem_write=1, mem_read=0, and mem_write_data is the merged word (or wdata for word stores).
    - -> DONE.
  - DONE: done=1, busy=1, mem_read=0, mem_write=0, err valid. -> IDLE.
- Latency, counted in posedges from the capture edge to the done-high cycle:
  - load 2
  - word store 2
  - byte/half store 3
  - error 1
- mem_read and mem_write are never high in the same cycle.
- rdata is not modified by stores or by errored transactions.
- Address wrap: the aligned address is formed by clearing the low bits only; no increment, so there are no carry or wrap cases.

Test Plan:
- Preload mem[0x10..0x13] = 88 99 AA BB. Load byte at 0x11, sign_ext=1 -> rdata=0xFFFFFF99, done 2 cycles after req. Same with sign_ext=0 -> rdata=0x00000099.
- Load half at 0x12, sign_ext=1 -> rdata=0xFFFFAABB. Load word at 0x10 -> rdata=0x8899AABB. mem_address=0x10 in every READ cycle.
- Store byte at 0x12, wdata=0x1234565C -> one mem_read cycle, then one mem_write cycle with mem_write_data=0x88995CBB. done 3 cycles after req; the word at 0x10 then reads back 0x88995CBB.
- Store word at 0x14, wdata=0xDEADBEEF -> mem_read never asserted, one mem_write cycle, done 2 cycles after req, memory holds DE AD BE EF at 0x14..0x17.
- Load half at 0x13, and separately size=11 at 0x10 -> done+err=1 one cycle after req, mem_read/mem_write stay 0, rdata unchanged. req pulses while busy=1 produce no extra done.
- Byte store at 0x12; drive rst_n=0 at the edge entering WRITE -> mem_write=0 after that edge, no done pulse, memory unchanged. After reset releases, a new load completes normally.
